// File: rtl/keypad_entry.sv
// keypad_entry
//
// Front end for a 4x4 matrix keypad on the vending machine. One column is
// driven low at a time; after the column has been held for a dwell period the
// synchronized rows are sampled. A press is debounced over several samples of
// the same frozen column. The key is then reported once, and the block waits
// for a debounced release before scanning resumes. Accepted digit keys build
// a two-digit decimal item number. '#' commits the number to item_id and '*'
// clears it.
//
// Parameters:
//   DWELL_CYCLES   - clock cycles each column is driven before sampling (>= 4)
//   DEBOUNCE_SCANS - matching samples needed to accept a press or release (>= 1)
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous reset, active low
//   row_sense    in   [3:0] keypad rows, active low, asynchronous to clk
//   col_drive    out  [3:0] keypad columns, one-cold
//   key_code     out  [3:0] code of the last accepted key
//   key_strobe   out  one-cycle pulse when a key is accepted
//   entry_digits out  [7:0] BCD entry in progress {tens, ones}
//   digit_count  out  [1:0] digits entered so far (0..2)
//   item_id      out  [6:0] last committed entry, binary 0..99
//   item_valid   out  one-cycle pulse when item_id updates
//   cancel       out  one-cycle pulse when '*' is accepted
//   entry_error  out  one-cycle pulse on a rejected key

module keypad_entry #(
  parameter int DWELL_CYCLES   = 40000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_sense,
  output logic [3:0] col_drive,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic [7:0] entry_digits,
  output logic [1:0] digit_count,
  output logic [6:0] item_id,
  output logic       item_valid,
  output logic       cancel,
  output logic       entry_error
);

  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  // A counter equal to CNT_LAST means the next matching sample is the last
  // one needed.
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_SCANS - 1);

  localparam logic [3:0] KEY_CANCEL = 4'hE;
  localparam logic [3:0] KEY_ENTER  = 4'hF;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_CONFIRM,
    ST_RELEASE
  } scan_state_t;

  scan_state_t        state;
  logic [3:0]         row_meta;
  logic [3:0]         row_sync;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               sample_point;
  logic [1:0]         col_idx;
  logic [1:0]         next_col;
  logic [1:0]         row_idx;
  logic [1:0]         low_row;
  logic               any_row_low;
  logic [CNT_W-1:0]   match_cnt;
  logic [CNT_W-1:0]   release_cnt;
  logic               key_is_digit;

  // Lowest-index row that is pulled low; only meaningful when a row is low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    casez (rows)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Map a (row, column) position to its key code. The first three rows and
  // columns form the 1..9 digit block. Column 3 carries A..D, and row 3
  // carries '*', '0' and '#'.
  function automatic logic [3:0] decode_key(input logic [1:0] row,
                                            input logic [1:0] col);
    logic [3:0] code;
    if (col == 2'd3) begin
      code = 4'hA + {2'b00, row};
    end else if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_CANCEL;
        2'd1:    code = 4'h0;
        default: code = KEY_ENTER;
      endcase
    end else begin
      code = (4'd3 * {2'b00, row}) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  function automatic logic [3:0] col_one_cold(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // tens*10 + ones, built from shifts: tens*8 + tens*2 + ones.
  function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
    return {bcd[7:4], 3'b000} + {2'b00, bcd[7:4], 1'b0} + {3'b000, bcd[3:0]};
  endfunction

  assign sample_point = (dwell_cnt == DWELL_LAST);
  assign next_col     = col_idx + 2'd1;
  assign any_row_low  = (row_sync != 4'hF);
  assign low_row      = lowest_low_row(row_sync);
  assign key_is_digit = (key_code <= 4'd9);

  // Two-flop synchronizer for the asynchronous row inputs. The rows reset to
  // the idle (all high) level so no phantom press is seen after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_sense;
      row_sync <= row_meta;
    end
  end

  // Free-running dwell counter. The terminal count is the sample point, and
  // column changes happen on the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_cnt <= '0;
    end else if (sample_point) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end

  // Scanner. The column only rotates while in SCAN with no press seen. It
  // stays frozen through CONFIRM and RELEASE, so keys in other columns are
  // invisible until the current key has been released. A failed confirm and
  // a completed release both continue the rotation from the next column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_SCAN;
      col_idx     <= 2'd0;
      col_drive   <= 4'b1110;
      row_idx     <= 2'd0;
      match_cnt   <= '0;
      release_cnt <= '0;
      key_code    <= 4'h0;
      key_strobe  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (sample_point) begin
        unique case (state)
          ST_SCAN: begin
            if (any_row_low) begin
              row_idx   <= low_row;
              match_cnt <= CNT_W'(1);
              // With single-sample debounce the first sighting is the accept.
              if (DEBOUNCE_SCANS <= 1) begin
                key_strobe  <= 1'b1;
                key_code    <= decode_key(low_row, col_idx);
                release_cnt <= '0;
                state       <= ST_RELEASE;
              end else begin
                state <= ST_CONFIRM;
              end
            end else begin
              col_idx   <= next_col;
              col_drive <= col_one_cold(next_col);
            end
          end

          ST_CONFIRM: begin
            if (!row_sync[row_idx]) begin
              if (match_cnt == CNT_LAST) begin
                key_strobe  <= 1'b1;
                key_code    <= decode_key(row_idx, col_idx);
                release_cnt <= '0;
                state       <= ST_RELEASE;
              end else begin
                match_cnt <= match_cnt + CNT_W'(1);
              end
            end else begin
              state     <= ST_SCAN;
              col_idx   <= next_col;
              col_drive <= col_one_cold(next_col);
            end
          end

          ST_RELEASE: begin
            if (!any_row_low) begin
              if (release_cnt == CNT_LAST) begin
                release_cnt <= '0;
                state       <= ST_SCAN;
                col_idx     <= next_col;
                col_drive   <= col_one_cold(next_col);
              end else begin
                release_cnt <= release_cnt + CNT_W'(1);
              end
            end else begin
              release_cnt <= '0;
            end
          end

          default: state <= ST_SCAN;
        endcase
      end
    end
  end

  // Entry accumulator. It acts on the registered strobe, so every entry
  // output moves one cycle after key_strobe. Digits shift in from the right.
  // '#' commits a non-empty entry, '*' abandons it, and A..D are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_digits <= 8'h00;
      digit_count  <= 2'd0;
      item_id      <= 7'd0;
      item_valid   <= 1'b0;
      cancel       <= 1'b0;
      entry_error  <= 1'b0;
    end else begin
      item_valid  <= 1'b0;
      cancel      <= 1'b0;
      entry_error <= 1'b0;
      if (key_strobe) begin
        if (key_is_digit) begin
          if (digit_count != 2'd2) begin
            entry_digits <= {entry_digits[3:0], key_code};
            digit_count  <= digit_count + 2'd1;
          end else begin
            entry_error <= 1'b1;
          end
        end else if (key_code == KEY_ENTER) begin
          if (digit_count != 2'd0) begin
            item_id      <= bcd_to_bin(entry_digits);
            item_valid   <= 1'b1;
            entry_digits <= 8'h00;
            digit_count  <= 2'd0;
          end else begin
            entry_error <= 1'b1;
          end
        end else if (key_code == KEY_CANCEL) begin
          cancel       <= 1'b1;
          entry_digits <= 8'h00;
          digit_count  <= 2'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry
//
// Testbench for keypad_entry, built with a short dwell and debounce so that
// scans are quick. A keypad model pulls a row low whenever a pressed key's
// column is being driven. Entry behaviour is predicted from the key rules
// with plain integer arithmetic.

module tb_keypad_entry;

  localparam int DWELL        = 8;
  localparam int DEB          = 3;
  localparam int PRESS_LIMIT  = (4 + DEB) * DWELL + 3;
  localparam int RELEASE_WAIT = (DEB + 2) * DWELL;

  logic       clk;
  logic       reset;
  logic [3:0] row_sense;
  logic [3:0] col_drive;
  logic [3:0] key_code;
  logic       key_strobe;
  logic [7:0] entry_digits;
  logic [1:0] digit_count;
  logic [6:0] item_id;
  logic       item_valid;
  logic       cancel;
  logic       entry_error;

  logic [15:0] pressed;
  logic [3:0]  keymap [16];

  int checks;
  int errors;
  int strobe_cnt;
  int valid_cnt;
  int cancel_cnt;
  int error_cnt;

  int m_tens;
  int m_ones;
  int m_count;
  int m_item;

  keypad_entry #(
    .DWELL_CYCLES  (DWELL),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row_sense   (row_sense),
    .col_drive   (col_drive),
    .key_code    (key_code),
    .key_strobe  (key_strobe),
    .entry_digits(entry_digits),
    .digit_count (digit_count),
    .item_id     (item_id),
    .item_valid  (item_valid),
    .cancel      (cancel),
    .entry_error (entry_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Key at row r, column c pulls row r low while column c is driven low.
  always_comb begin
    row_sense = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && (col_drive[c] == 1'b0)) row_sense[r] = 1'b0;
      end
    end
  end

  // Pulse counters, counting high cycles so a stretched pulse counts twice.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (key_strobe === 1'b1)  strobe_cnt++;
      if (item_valid === 1'b1)  valid_cnt++;
      if (cancel === 1'b1)      cancel_cnt++;
      if (entry_error === 1'b1) error_cnt++;
    end
  end

  function automatic int key_pos(input logic [3:0] code);
    int pos;
    pos = 0;
    for (int i = 0; i < 16; i++) if (keymap[i] == code) pos = i;
    return pos;
  endfunction

  task automatic model_clear();
    m_tens  = 0;
    m_ones  = 0;
    m_count = 0;
    m_item  = 0;
  endtask

  // Entry rules applied to one accepted key.
  task automatic model_key(input logic [3:0] code, output bit ev, output bit ec, output bit ee);
    ev = 1'b0;
    ec = 1'b0;
    ee = 1'b0;
    if (code <= 4'd9) begin
      if (m_count < 2) begin
        m_tens = m_ones;
        m_ones = int'(code);
        m_count++;
      end else begin
        ee = 1'b1;
      end
    end else if (code == 4'hF) begin
      if (m_count >= 1) begin
        m_item  = m_tens * 10 + m_ones;
        ev      = 1'b1;
        m_tens  = 0;
        m_ones  = 0;
        m_count = 0;
      end else begin
        ee = 1'b1;
      end
    end else if (code == 4'hE) begin
      ec      = 1'b1;
      m_tens  = 0;
      m_ones  = 0;
      m_count = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    pressed = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  // Wait, bounded, for the cycle on which column `col` has just been driven.
  task automatic align_to_column(input logic [3:0] col);
    int waited;
    waited = 0;
    while (col_drive === col && waited < 100) begin @(negedge clk); waited++; end
    while (col_drive !== col && waited < 100) begin @(negedge clk); waited++; end
    checks++;
    if (waited >= 100) begin
      errors++;
      $display("[TB] FAIL align_timeout: col_drive=%b waiting for %b", col_drive, col);
    end
  endtask

  // Press one key (or use a key already held), check the strobe, the entry
  // outputs and the pulses, then release and check that nothing repeated.
  task automatic press_and_check(input logic [3:0] code, input int extra_hold, input bit already_held);
    int pos, waited, s0, v0, c0, e0;
    bit ev, ec, ee;
    logic [7:0] old_digits;
    pos        = key_pos(code);
    old_digits = 8'(m_tens * 16 + m_ones);
    model_key(code, ev, ec, ee);
    s0 = strobe_cnt;
    v0 = valid_cnt;
    c0 = cancel_cnt;
    e0 = error_cnt;
    if (!already_held) pressed[pos] = 1'b1;
    waited = 0;
    while (key_strobe !== 1'b1 && waited < PRESS_LIMIT) begin @(negedge clk); waited++; end
    checks++;
    if (key_strobe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL strobe_timeout key %h: no strobe within %0d cycles", code, PRESS_LIMIT);
    end else begin
      checks++;
      if (key_code !== code) begin
        errors++;
        $display("[TB] FAIL key_code: got %h expected %h", key_code, code);
      end
      checks++;
      if (entry_digits !== old_digits) begin
        errors++;
        $display("[TB] FAIL entry_early key %h: got %h expected %h", code, entry_digits, old_digits);
      end
      @(negedge clk);
      checks++;
      if (key_strobe !== 1'b0) begin
        errors++;
        $display("[TB] FAIL strobe_width key %h: got %b expected 0", code, key_strobe);
      end
      checks++;
      if (entry_digits !== 8'(m_tens * 16 + m_ones)) begin
        errors++;
        $display("[TB] FAIL entry_digits key %h: got %h expected %h", code, entry_digits, 8'(m_tens * 16 + m_ones));
      end
      checks++;
      if (digit_count !== 2'(m_count)) begin
        errors++;
        $display("[TB] FAIL digit_count key %h: got %0d expected %0d", code, digit_count, m_count);
      end
      checks++;
      if (item_id !== 7'(m_item)) begin
        errors++;
        $display("[TB] FAIL item_id key %h: got %0d expected %0d", code, item_id, m_item);
      end
      checks++;
      if ({item_valid, cancel, entry_error} !== {ev, ec, ee}) begin
        errors++;
        $display("[TB] FAIL pulses key %h: got v/c/e %b%b%b expected %b%b%b",
                 code, item_valid, cancel, entry_error, ev, ec, ee);
      end
    end
    repeat (extra_hold) @(negedge clk);
    pressed[pos] = 1'b0;
    repeat (RELEASE_WAIT) @(negedge clk);
    checks++;
    if (strobe_cnt - s0 != 1) begin
      errors++;
      $display("[TB] FAIL strobe_count key %h: got %0d expected 1", code, strobe_cnt - s0);
    end
    checks++;
    if ((valid_cnt - v0 != int'(ev)) || (cancel_cnt - c0 != int'(ec)) || (error_cnt - e0 != int'(ee))) begin
      errors++;
      $display("[TB] FAIL pulse_count key %h: got v/c/e %0d/%0d/%0d expected %0d/%0d/%0d",
               code, valid_cnt - v0, cancel_cnt - c0, error_cnt - e0, ev, ec, ee);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    repeat (3) @(negedge clk);
    checks++;
    if (col_drive !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL reset_col: got %b expected 1110", col_drive);
    end
    checks++;
    if ({key_code, key_strobe, entry_digits, digit_count, item_id, item_valid, cancel, entry_error} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got code %h strobe %b digits %h count %0d item %0d v/c/e %b%b%b expected all 0",
               key_code, key_strobe, entry_digits, digit_count, item_id, item_valid, cancel, entry_error);
    end
    reset = 1'b1;
    model_clear();
    for (int k = 1; k <= 4 * DWELL + 1; k++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / DWELL) % 4));
      checks++;
      if (col_drive !== exp_col) begin
        errors++;
        $display("[TB] FAIL rotation cycle %0d: got %b expected %b", k, col_drive, exp_col);
      end
    end
  endtask

  task automatic test_single_press();
    do_reset();
    press_and_check(4'h5, 20 * DWELL - 20, 1'b0);
  endtask

  task automatic test_entry();
    do_reset();
    press_and_check(4'h4, $urandom_range(0, 10), 1'b0);
    press_and_check(4'h2, $urandom_range(0, 10), 1'b0);
    press_and_check(4'hF, $urandom_range(0, 10), 1'b0);
    checks++;
    if (item_id !== 7'd42) begin
      errors++;
      $display("[TB] FAIL entry_item: got %0d expected 42", item_id);
    end
  endtask

  task automatic test_bounce();
    int s0;
    do_reset();
    align_to_column(4'b1011);
    s0 = strobe_cnt;
    pressed[6] = 1'b1;
    repeat (2 * DWELL) @(negedge clk);
    pressed[6] = 1'b0;
    repeat (DWELL - 1) @(negedge clk);
    checks++;
    if (col_drive !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL bounce_frozen: got %b expected 1011", col_drive);
    end
    @(negedge clk);
    checks++;
    if (col_drive !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL bounce_resume: got %b expected 0111", col_drive);
    end
    repeat (DWELL) @(negedge clk);
    checks++;
    if (col_drive !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL bounce_scan: got %b expected 1110", col_drive);
    end
    repeat (RELEASE_WAIT) @(negedge clk);
    checks++;
    if (strobe_cnt != s0 || digit_count !== 2'd0) begin
      errors++;
      $display("[TB] FAIL bounce_strobe: got %0d strobes count %0d expected 0 strobes count 0",
               strobe_cnt - s0, digit_count);
    end
  endtask

  task automatic test_errors();
    do_reset();
    press_and_check(4'h1, 3, 1'b0);
    press_and_check(4'h2, 3, 1'b0);
    press_and_check(4'h3, 3, 1'b0);
    press_and_check(4'hF, 3, 1'b0);
    press_and_check(4'hF, 3, 1'b0);
    press_and_check(4'h7, 3, 1'b0);
    press_and_check(4'hE, 3, 1'b0);
    checks++;
    if (item_id !== 7'd12 || digit_count !== 2'd0) begin
      errors++;
      $display("[TB] FAIL errors_final: got item %0d count %0d expected item 12 count 0", item_id, digit_count);
    end
  endtask

  task automatic test_reset_mid_confirm();
    int s0;
    do_reset();
    press_and_check(4'h3, 2, 1'b0);
    press_and_check(4'hF, 2, 1'b0);
    press_and_check(4'h8, 2, 1'b0);
    align_to_column(4'b1101);
    s0 = strobe_cnt;
    pressed[5] = 1'b1;
    repeat (DWELL + 2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (col_drive !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL midreset_col: got %b expected 1110", col_drive);
    end
    checks++;
    if ({key_code, key_strobe, entry_digits, digit_count, item_id, item_valid, cancel, entry_error} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got code %h digits %h count %0d item %0d expected all 0",
               key_code, entry_digits, digit_count, item_id);
    end
    checks++;
    if (strobe_cnt != s0) begin
      errors++;
      $display("[TB] FAIL midreset_strobe: got %0d strobes expected 0", strobe_cnt - s0);
    end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    press_and_check(4'h5, 10, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] code;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      code = 4'($urandom_range(0, 15));
      press_and_check(code, $urandom_range(0, 30), 1'b0);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    strobe_cnt = 0;
    valid_cnt  = 0;
    cancel_cnt = 0;
    error_cnt  = 0;
    keymap = '{4'h1, 4'h2, 4'h3, 4'hA,
               4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC,
               4'hE, 4'h0, 4'hF, 4'hD};
    model_clear();
    pressed = '0;
    reset   = 1'b1;
    #1 reset = 1'b0;
    $display("[TB] reset");
    test_reset();
    $display("[TB] single press");
    test_single_press();
    $display("[TB] entry");
    test_entry();
    $display("[TB] bounce");
    test_bounce();
    $display("[TB] errors");
    test_errors();
    $display("[TB] reset mid-confirm");
    test_reset_mid_confirm();
    $display("[TB] random keys");
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
